// File: rtl/u41_pkg.sv
// u41_pkg: shared definitions for the 4-input permutation normalisers.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
//
// Contents:
//   TT_W, CODE_W  truth-table and permutation-code widths
//   N_PERMS       number of input permutations of a 4-input function
//   PERM_TABLE    permutation codes {p3,p2,p1,p0}, 2 bits each, in table order
//   state_t       sequencer states (IDLE/RUN/DONE)
//   ppc_legal()   true when a permutations-per-cycle value divides the table evenly
package u41_pkg;

  localparam int TT_W    = 16;
  localparam int CODE_W  = 8;
  localparam int N_PERMS = 24;

  // Index 0 is the identity; field p3 (code[7:6]) describes minterm-index bit 0,
  // p0 (code[1:0]) describes minterm-index bit 3. The field value names the
  // source minterm-index bit that the output bit is taken from.
  localparam logic [CODE_W-1:0] PERM_TABLE [N_PERMS] = '{
    8'h1B, 8'h1E, 8'h27, 8'h36, 8'h2D, 8'h39,   // 0123 0132 0213 0312 0231 0321
    8'h4B, 8'h4E, 8'h87, 8'hC6, 8'h8D, 8'hC9,   // 1023 1032 2013 3012 2031 3021
    8'h63, 8'h72, 8'h93, 8'hD2, 8'hB1, 8'hE1,   // 1203 1302 2103 3102 2301 3201
    8'h6C, 8'h78, 8'h9C, 8'hD8, 8'hB4, 8'hE4    // 1230 1320 2130 3120 2310 3210
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Every divisor of 24 is a legal evaluator count; anything else is not.
  function automatic bit ppc_legal(int p);
    return (p >= 1) && (p <= N_PERMS) && ((N_PERMS % p) == 0);
  endfunction

endpackage

// File: rtl/u41_perm_apply.sv
// u41_perm_apply: applies one input permutation to a 4-input truth table.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   func   in  16  truth table, bit15 = minterm 0 ... bit0 = minterm 15
//   perm   in  8   permutation code {p3,p2,p1,p0}
//   pfunc  out 16  permuted truth table
module u41_perm_apply
  import u41_pkg::*;
(
  input  logic [TT_W-1:0]   func,
  input  logic [CODE_W-1:0] perm,
  output logic [TT_W-1:0]   pfunc
);

  // mo: output minterm index, mi: input minterm index it is fetched from.
  logic [3:0] mo;
  logic [3:0] mi;

  // For every output minterm, bit j of its index is written to bit p(j) of the
  // source index. Minterm m lives at vector bit 15-m, which is ~m in 4 bits.
  always_comb begin
    pfunc = '0;
    mo    = '0;
    mi    = '0;
    for (int m = 0; m < 16; m++) begin
      mo = 4'(m);
      mi = '0;
      for (int j = 0; j < 4; j++) begin
        mi[perm[2*(3-j) +: 2]] = mo[j];
      end
      pfunc[~mo] = func[~mi];
    end
  end

endmodule

// File: rtl/u41_norm_seq.sv
// u41_norm_seq: sequenced permutation normaliser, smallest permuted table + its code.
// Latency: out_valid rises N_STEPS = 24/PERMS_PER_CYCLE cycles after the accepting edge.
// Backpressure: single request in flight; in_ready stays low until the result is taken.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_ready = state IDLE
//   in_func   [15:0]      truth table to normalise, latched on accept
//   out_valid/out_ready   result handshake; result held while stalled
//   out_norm  [15:0]      minimal permuted truth table
//   out_perm  [7:0]       permutation code producing out_norm (lowest index on ties)
//   busy                  high in RUN or DONE
module u41_norm_seq
  import u41_pkg::*;
#(
  parameter int PERMS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TT_W-1:0]   in_func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TT_W-1:0]   out_norm,
  output logic [CODE_W-1:0] out_perm,
  output logic              busy
);

  localparam int P       = PERMS_PER_CYCLE;
  localparam int N_STEPS = N_PERMS / P;
  localparam int CW      = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int IW      = $clog2(N_PERMS);
  // Reduction tree is padded to a power of two; padding leaves are never valid.
  localparam int LV      = (P > 1) ? $clog2(P) : 0;
  localparam int NL      = 1 << LV;
  localparam logic [CW-1:0] LAST_STEP = CW'(N_STEPS - 1);

  if (!ppc_legal(PERMS_PER_CYCLE)) begin : g_bad_ppc
    $error("u41_norm_seq: PERMS_PER_CYCLE must divide 24");
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     cnt_q;
  logic [TT_W-1:0]   func_q;
  logic [TT_W-1:0]   best_norm_q;
  logic [CODE_W-1:0] best_perm_q;

  logic              accept;
  logic [TT_W-1:0]   red_norm;
  logic [CODE_W-1:0] red_code;

  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)              state_d = RUN;
      RUN:     if (cnt_q == LAST_STEP)    state_d = DONE;
      DONE:    if (out_ready)             state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign out_norm = best_norm_q;
  assign out_perm = best_perm_q;

  // ---------------------------------------------------------------------------
  // Permutation evaluators: lane j handles table entry cnt*P + j
  // ---------------------------------------------------------------------------
  logic [TT_W-1:0]   cand_norm [NL];
  logic [CODE_W-1:0] cand_code [NL];

  for (genvar j = 0; j < NL; j++) begin : g_lane
    if (j < P) begin : g_eval
      logic [IW-1:0] idx;
      assign idx          = IW'(int'(cnt_q) * P + j);
      assign cand_code[j] = PERM_TABLE[idx];
      u41_perm_apply u_apply (
        .func  (func_q),
        .perm  (cand_code[j]),
        .pfunc (cand_norm[j])
      );
    end else begin : g_pad
      assign cand_norm[j] = '0;
      assign cand_code[j] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Tie-aware min tree. Node i combines children 2i (lower indices) and 2i+1;
  // the right child only wins when strictly smaller, so equal minima resolve
  // to the lowest table index within the step.
  // ---------------------------------------------------------------------------
  logic [TT_W-1:0]   t_norm [2*NL];
  logic [CODE_W-1:0] t_code [2*NL];
  logic              t_vld  [2*NL];

  always_comb begin
    for (int i = 0; i < 2*NL; i++) begin
      t_norm[i] = '0;
      t_code[i] = '0;
      t_vld[i]  = 1'b0;
    end
    for (int j = 0; j < NL; j++) begin
      t_norm[NL+j] = cand_norm[j];
      t_code[NL+j] = cand_code[j];
      t_vld[NL+j]  = (j < P);
    end
    for (int i = NL - 1; i >= 1; i--) begin
      if (t_vld[2*i+1] && (!t_vld[2*i] || (t_norm[2*i+1] < t_norm[2*i]))) begin
        t_norm[i] = t_norm[2*i+1];
        t_code[i] = t_code[2*i+1];
      end else begin
        t_norm[i] = t_norm[2*i];
        t_code[i] = t_code[2*i];
      end
      t_vld[i] = t_vld[2*i] | t_vld[2*i+1];
    end
  end

  assign red_norm = t_norm[1];
  assign red_code = t_code[1];

  // ---------------------------------------------------------------------------
  // Datapath: latched request, step counter, running best
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q      <= '0;
      cnt_q       <= '0;
      best_norm_q <= '0;
      best_perm_q <= '0;
    end else if (accept) begin
      func_q <= in_func;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      // Step 0 seeds the accumulator; later steps replace only on strictly
      // smaller, so earlier (lower-index) steps keep ties.
      if ((cnt_q == '0) || (red_norm < best_norm_q)) begin
        best_norm_q <= red_norm;
        best_perm_q <= red_code;
      end
      // Counter stops at the last step rather than wrapping.
      if (cnt_q != LAST_STEP) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule
